hazard_control_unit: RTL



---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_control_unit_if.sv | 36 +++
 rtl/hazard_down_counter.sv | 26 ++
 rtl/hazard_control_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard control unit: load-stall FSM states,
// performance counter width, and the down-counter width helper.
package hazard_pkg;

  localparam int PERF_W = 32;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } loadState_t;

  // Bits needed to hold any value 0..maxVal; illegal values still yield a usable width.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle of the hazard control unit: ID/EX operand info in,
// hold/bubble/flush controls and perf counts out.
interface hazard_control_unit_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
);
  logic                  BranchControl;
  logic                  ID_EX_MemRead;
  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt;
  logic                  IF_ID_UsesRt;
  logic                  IF_ID_ReadsHiLo;
  logic                  MDU_Start;
  logic                  Stall;
  logic                  Bubble;
  logic                  Flush;
  logic                  MDU_Busy;
  logic [PERF_W-1:0]     StallCycles;
  logic [PERF_W-1:0]     FlushCycles;

  // Pipeline side drives the instruction info and consumes the controls.
  modport master (
    output BranchControl, ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs,
           IF_ID_RegisterRt, IF_ID_UsesRt, IF_ID_ReadsHiLo, MDU_Start,
    input  Stall, Bubble, Flush, MDU_Busy, StallCycles, FlushCycles
  );

  modport slave (
    input  BranchControl, ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs,
           IF_ID_RegisterRt, IF_ID_UsesRt, IF_ID_ReadsHiLo, MDU_Start,
    output Stall, Bubble, Flush, MDU_Busy, StallCycles, FlushCycles
  );

endinterface

// File: rtl/hazard_down_counter.sv
// Loadable down-counter that stops at zero; clear has priority over load,
// load over decrement.
module hazard_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: multi-cycle load-use stall, MDU HI/LO interlock and
// multi-cycle branch flush. Define HAZARD_PERF_CNT_EN to build the perf counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_LATENCY       = 4,
  parameter int FLUSH_CYCLES      = 1
) (
  input logic                  clk,
  input logic                  reset,
  hazard_control_unit_if.slave hz
);

  localparam int LD_W  = cntWidth(LOAD_STALL_CYCLES);
  localparam int MDU_W = cntWidth(MDU_LATENCY);
  localparam int FL_W  = cntWidth(FLUSH_CYCLES);

  if (REG_ADDR_W < 1 || LOAD_STALL_CYCLES < 1 || MDU_LATENCY < 1 || FLUSH_CYCLES < 1) begin : gBadParam
    $error("hazard_control_unit: all parameters must be >= 1");
  end

  logic [REG_ADDR_W-1:0] exRt, idRs, idRt;
  logic                  loadHaz, mdHaz, mduBusy, flush, stall, stallReq;
  logic                  loadStart, ldLast;
  logic [LD_W-1:0]       ldCnt;
  logic [MDU_W-1:0]      mduCnt;
  logic [FL_W-1:0]       flCnt;
  loadState_t            state, stateNext;

  assign exRt = hz.ID_EX_RegisterRt;
  assign idRs = hz.IF_ID_RegisterRs;
  assign idRt = hz.IF_ID_RegisterRt;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign loadHaz = hz.ID_EX_MemRead && (exRt != '0) &&
                   ((exRt == idRs) || (hz.IF_ID_UsesRt && (exRt == idRt)));

  assign mduBusy   = (mduCnt != '0);
  assign mdHaz     = mduBusy && hz.IF_ID_ReadsHiLo;
  assign flush     = hz.BranchControl || (flCnt != '0);
  assign loadStart = (state == IDLE) && loadHaz && !flush;
  assign ldLast    = (ldCnt == LD_W'(1));

  hazard_down_counter #(.WIDTH(LD_W)) uLdCnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .load    (loadStart),
    .loadVal (LD_W'(LOAD_STALL_CYCLES - 1)),
    .count   (ldCnt)
  );

  // The MDU op is older than any flushed instruction, so flush never clears it.
  hazard_down_counter #(.WIDTH(MDU_W)) uMduCnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (1'b0),
    .load    (hz.MDU_Start),
    .loadVal (MDU_W'(MDU_LATENCY)),
    .count   (mduCnt)
  );

  hazard_down_counter #(.WIDTH(FL_W)) uFlCnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (1'b0),
    .load    (hz.BranchControl),
    .loadVal (FL_W'(FLUSH_CYCLES - 1)),
    .count   (flCnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:       if (loadStart && (LOAD_STALL_CYCLES > 1)) stateNext = LOAD_STALL;
      LOAD_STALL: if (flush || ldLast) stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  // A flush discards the dependent instruction, so it silences every stall source.
  always_comb begin
    stallReq = mdHaz;
    unique case (state)
      IDLE:       stallReq = stallReq || loadHaz;
      LOAD_STALL: stallReq = 1'b1;
      default:    stallReq = mdHaz;
    endcase
    stall = stallReq && !flush;
  end

  assign hz.Stall    = stall;
  assign hz.Bubble   = stall;
  assign hz.Flush    = flush;
  assign hz.MDU_Busy = mduBusy;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stallCycles, flushCycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
      flushCycles <= '0;
    end else begin
      if (stall && (stallCycles != '1)) stallCycles <= stallCycles + PERF_W'(1);
      if (flush && (flushCycles != '1)) flushCycles <= flushCycles + PERF_W'(1);
    end
  end

  assign hz.StallCycles = stallCycles;
  assign hz.FlushCycles = flushCycles;
`else
  assign hz.StallCycles = '0;
  assign hz.FlushCycles = '0;
`endif

endmodule
